pipeline_sink: RTL and testbench

- Terminating end of the global-stall pipeline: captures the pipeline's output beats (data, valid, flush echo) into a small FIFO and re-presents them to a downstream consumer over a valid/ready handshake.
- Drives the pipeline's global `stall` from FIFO occupancy.
- Launches pipeline flushes on downstream request, discarding in-flight beats until the flush echo returns.

---
 rtl/pipeline_pkg.sv | 15 +
 rtl/sink_fifo.sv | 71 +++++++
 rtl/pipeline_sink.sv | 103 ++++++++++
 tb/tb_pipeline_sink.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared types and defaults for the global-stall pipeline and its sink.
package pipeline_pkg;

  localparam int DATA_W_DEF        = 32;
  localparam int DEPTH_DEF         = 8;
  localparam int STALL_THRESH_DEF  = 4;
  localparam int FLUSH_TIMEOUT_DEF = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    DRAIN = 2'd2
  } sink_state_t;

endpackage

// File: rtl/sink_fifo.sv
// Circular-buffer FIFO for the pipeline sink: registered head, push/pop
// arbitration with pass-through when full, and a synchronous clear.
module sink_fifo
  import pipeline_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              push_req,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              drop,
  output logic [CW-1:0]     count,
  output logic [CW-1:0]     count_next
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              push;
  logic              pop;

  assign rd_valid = (count != '0);
  assign rd_data  = mem[rd_ptr];
  assign pop      = rd_valid & rd_ready;
  // A full FIFO still accepts a beat when the head leaves in the same cycle.
  assign push     = push_req & ((count < CW'(DEPTH)) | pop);
  assign drop     = push_req & ~push;

  always_comb begin
    count_next = count;
    if (clr) begin
      count_next = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_next = count + CW'(1);
        2'b01:   count_next = count - CW'(1);
        default: count_next = count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      count <= count_next;
      if (clr) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) begin
          mem[wr_ptr] <= wr_data;
          wr_ptr      <= wr_ptr + PW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

endmodule

// File: rtl/pipeline_sink.sv
// Terminating end of the global-stall pipeline: buffers output beats, drives
// stall from occupancy, and sequences downstream-requested flushes.
module pipeline_sink
  import pipeline_pkg::*;
#(
  parameter int DATA_W        = DATA_W_DEF,
  parameter int DEPTH         = DEPTH_DEF,
  parameter int STALL_THRESH  = STALL_THRESH_DEF,
  parameter int FLUSH_TIMEOUT = FLUSH_TIMEOUT_DEF,
  localparam int CW           = $clog2(DEPTH + 1),
  localparam int TW           = $clog2(FLUSH_TIMEOUT + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] pipe_data,
  input  logic              pipe_valid,
  input  logic              pipe_flush,
  output logic              stall,
  output logic              flush,
  input  logic              flush_req,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [CW-1:0]     count,
  output logic              busy,
  output logic              overflow,
  output logic              flush_err
);

  sink_state_t   state;
  sink_state_t   state_next;
  logic [TW-1:0] tmo_cnt;
  logic [TW-1:0] tmo_next;
  logic          timeout;
  logic          drop;
  logic [CW-1:0] count_next;

  assign busy = (state != IDLE);

  sink_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .clr        (state == FLUSH),
    .push_req   (pipe_valid & (state == IDLE)),
    .wr_data    (pipe_data),
    .rd_ready   (m_ready),
    .rd_data    (m_data),
    .rd_valid   (m_valid),
    .drop       (drop),
    .count      (count),
    .count_next (count_next)
  );

  always_comb begin
    state_next = state;
    tmo_next   = tmo_cnt;
    timeout    = 1'b0;
    case (state)
      IDLE: begin
        if (flush_req) state_next = FLUSH;
      end
      FLUSH: begin
        tmo_next   = '0;
        state_next = DRAIN;
      end
      DRAIN: begin
        // The echo wins over a timeout that expires in the same cycle.
        if (pipe_flush) begin
          state_next = IDLE;
        end else if (tmo_cnt == TW'(FLUSH_TIMEOUT - 1)) begin
          timeout    = 1'b1;
          state_next = IDLE;
        end else begin
          tmo_next = tmo_cnt + TW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      tmo_cnt   <= '0;
      flush     <= 1'b0;
      stall     <= 1'b0;
      overflow  <= 1'b0;
      flush_err <= 1'b0;
    end else begin
      state     <= state_next;
      tmo_cnt   <= tmo_next;
      flush     <= (state_next == FLUSH);
      // Stall tracks next occupancy so it is aligned with count; held low while flushing.
      stall     <= (state_next == IDLE) && (count_next >= CW'(STALL_THRESH));
      overflow  <= overflow | drop;
      flush_err <= flush_err | timeout;
    end
  end

endmodule

// File: tb/tb_pipeline_sink.sv
// Directed-vector bench for pipeline_sink: flow, backpressure, full pass-through,
// flush, flush timeout and reset during a flush.
module tb_pipeline_sink;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pipe_data;
  logic        pipe_valid;
  logic        pipe_flush;
  logic        stall;
  logic        flush;
  logic        flush_req;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic [3:0]  count;
  logic        busy;
  logic        overflow;
  logic        flush_err;

  int vectors    = 0;
  int miscompares = 0;

  pipeline_sink dut (
    .clk        (clk),
    .reset      (reset),
    .pipe_data  (pipe_data),
    .pipe_valid (pipe_valid),
    .pipe_flush (pipe_flush),
    .stall      (stall),
    .flush      (flush),
    .flush_req  (flush_req),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .count      (count),
    .busy       (busy),
    .overflow   (overflow),
    .flush_err  (flush_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b0;
    pipe_data  = '0;
    pipe_valid = 1'b0;
    pipe_flush = 1'b0;
    flush_req  = 1'b0;
    m_ready    = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({m_valid, count, stall, flush, busy, overflow, flush_err} !== 10'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b want 0", {m_valid, count, stall, flush, busy, overflow, flush_err});
    end
    vectors++;
    if (m_data !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_m_data: got %h want 0", m_data);
    end
  endtask

  task automatic test_basic();
    logic [31:0] exp [3] = '{32'h11, 32'h22, 32'h33};
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pipe_valid = 1'b1;
      pipe_data  = exp[i];
      step();
      vectors++;
      if (m_valid !== 1'b1 || m_data !== exp[i]) begin
        miscompares++;
        $display("FAIL basic_data[%0d]: got v=%b %h want v=1 %h", i, m_valid, m_data, exp[i]);
      end
      vectors++;
      if (count !== 4'd1 || stall !== 1'b0) begin
        miscompares++;
        $display("FAIL basic_count[%0d]: got count=%0d stall=%b want 1/0", i, count, stall);
      end
    end
    pipe_valid = 1'b0;
    step();
    vectors++;
    if (count !== 4'd0 || m_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_empty: got count=%0d v=%b want 0/0", count, m_valid);
    end
  endtask

  task automatic test_backpressure();
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      pipe_valid = 1'b1;
      pipe_data  = 32'(i + 1);
      step();
      vectors++;
      if (count !== 4'(i + 1) || stall !== (i >= 3)) begin
        miscompares++;
        $display("FAIL bp_fill[%0d]: got count=%0d stall=%b want %0d/%b", i, count, stall, i + 1, i >= 3);
      end
    end
    vectors++;
    if (overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_no_overflow: got %b want 0", overflow);
    end
    pipe_data = 32'h9;
    step();
    vectors++;
    if (count !== 4'd8 || overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_overflow: got count=%0d ovf=%b want 8/1", count, overflow);
    end
    pipe_valid = 1'b0;
    m_ready    = 1'b1;
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (m_data !== 32'(i + 1)) begin
        miscompares++;
        $display("FAIL bp_drain[%0d]: got %h want %h", i, m_data, i + 1);
      end
      step();
      vectors++;
      if (count !== 4'(7 - i) || stall !== (7 - i >= 4)) begin
        miscompares++;
        $display("FAIL bp_stall[%0d]: got count=%0d stall=%b want %0d/%b", i, count, stall, 7 - i, 7 - i >= 4);
      end
    end
  endtask

  task automatic test_full_simul();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      pipe_valid = 1'b1;
      pipe_data  = 32'hA0 + 32'(i);
      step();
    end
    vectors++;
    if (count !== 4'd8) begin
      miscompares++;
      $display("FAIL full_fill: got %0d want 8", count);
    end
    m_ready   = 1'b1;
    pipe_data = 32'hAA;
    step();
    pipe_valid = 1'b0;
    vectors++;
    if (count !== 4'd8 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL full_passthru: got count=%0d ovf=%b want 8/0", count, overflow);
    end
    for (int i = 0; i < 8; i++) begin
      logic [31:0] e;
      e = (i < 7) ? 32'hA1 + 32'(i) : 32'hAA;
      vectors++;
      if (m_data !== e || m_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL full_drain[%0d]: got v=%b %h want v=1 %h", i, m_valid, m_data, e);
      end
      step();
    end
    vectors++;
    if (m_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL full_empty: got %b want 0", m_valid);
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      pipe_valid = 1'b1;
      pipe_data  = 32'h50 + 32'(i);
      step();
    end
    pipe_valid = 1'b0;
    flush_req  = 1'b1;
    step();
    flush_req = 1'b0;
    vectors++;
    if (flush !== 1'b1 || busy !== 1'b1 || stall !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_pulse: got flush=%b busy=%b stall=%b want 1/1/0", flush, busy, stall);
    end
    pipe_valid = 1'b1;
    pipe_data  = 32'hBB;
    step();
    pipe_valid = 1'b0;
    vectors++;
    if (flush !== 1'b0 || m_valid !== 1'b0 || count !== 4'd0 || stall !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_drain: got flush=%b v=%b count=%0d stall=%b busy=%b want 0/0/0/0/1",
               flush, m_valid, count, stall, busy);
    end
    step();
    vectors++;
    if (count !== 4'd0 || overflow !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_discard: got count=%0d ovf=%b busy=%b want 0/0/1", count, overflow, busy);
    end
    step();
    pipe_flush = 1'b1;
    step();
    pipe_flush = 1'b0;
    vectors++;
    if (busy !== 1'b0 || flush_err !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_echo: got busy=%b err=%b want 0/0", busy, flush_err);
    end
    pipe_valid = 1'b1;
    pipe_data  = 32'hCC;
    step();
    vectors++;
    if (m_data !== 32'hCC || m_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_resume: got v=%b %h want v=1 cc", m_valid, m_data);
    end
    pipe_flush = 1'b1;
    pipe_data  = 32'hDD;
    step();
    pipe_flush = 1'b0;
    pipe_valid = 1'b0;
    vectors++;
    if (busy !== 1'b0 || count !== 4'd2) begin
      miscompares++;
      $display("FAIL idle_echo: got busy=%b count=%0d want 0/2", busy, count);
    end
  endtask

  task automatic test_timeout();
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      step();
      vectors++;
      if (busy !== 1'b1 || flush_err !== 1'b0) begin
        miscompares++;
        $display("FAIL tmo_wait[%0d]: got busy=%b err=%b want 1/0", i, busy, flush_err);
      end
    end
    step();
    vectors++;
    if (busy !== 1'b0 || flush_err !== 1'b1) begin
      miscompares++;
      $display("FAIL tmo_expire: got busy=%b err=%b want 0/1", busy, flush_err);
    end
    pipe_valid = 1'b1;
    pipe_data  = 32'h5A;
    step();
    pipe_valid = 1'b0;
    vectors++;
    if (m_data !== 32'h5A || count !== 4'd1) begin
      miscompares++;
      $display("FAIL tmo_resume: got %h count=%0d want 5a/1", m_data, count);
    end
  endtask

  task automatic test_reset_mid_flush();
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pipe_valid = 1'b1;
      pipe_data  = 32'h70 + 32'(i);
      step();
    end
    pipe_valid = 1'b0;
    flush_req  = 1'b1;
    step();
    flush_req = 1'b0;
    #3;
    reset = 1'b0;
    #1;
    vectors++;
    if ({busy, flush, stall, count, m_valid, flush_err} !== 9'b0) begin
      miscompares++;
      $display("FAIL rst_in_flush: got busy=%b flush=%b stall=%b count=%0d v=%b err=%b want all 0",
               busy, flush, stall, count, m_valid, flush_err);
    end
    step();
    reset     = 1'b1;
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    step();
    #3;
    reset = 1'b0;
    #1;
    vectors++;
    if ({busy, flush, stall, count, m_valid} !== 8'b0) begin
      miscompares++;
      $display("FAIL rst_in_drain: got busy=%b flush=%b stall=%b count=%0d v=%b want all 0",
               busy, flush, stall, count, m_valid);
    end
    step();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (flush !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL rst_no_pulse[%0d]: got flush=%b busy=%b want 0/0", i, flush, busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_full_simul();
    test_flush();
    test_timeout();
    test_reset_mid_flush();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
